// File: rtl/serial_carryadder.sv
// ----------------------------------------------------------------------------
// serial_carryadder
//
// Digit-serial adder/subtractor. One WIDTH-bit operation is processed DIGIT
// bits per clock, least-significant digit first, through a single DIGIT-bit
// ripple-carry slice whose carry is held in a register between digits.
// Only one operation is in flight at a time.
//
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE. Once
// out_valid is high, sum/cout/ovf stay stable until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (registered)
//   a, b       WIDTH-bit operands
//   cin        carry-in (sub=0) or borrow-in (sub=1)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid (registered)
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry-out (sub=0) or borrow-out (sub=1)
//   ovf        two's-complement signed overflow
// ----------------------------------------------------------------------------
module serial_carryadder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;

   // Digit slice signals
   logic [DIGIT-1:0] a_d;
   logic [DIGIT-1:0] b_d;
   logic [DIGIT-1:0] res;
   logic             c_out;
   logic             c_msb_in;
   logic [WIDTH-1:0] res_w;
   logic [WIDTH-1:0] sum_next;

   // The latched operands shift right one digit per cycle, so the digit being
   // worked on always sits in the low DIGIT bits. The result shifts in from
   // the top; after N digits every result bit has landed in its final place.
   always_comb begin
      a_d      = a_q[DIGIT-1:0];
      b_d      = b_q[DIGIT-1:0];
      {c_out, res} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
      // Carry into the slice MSB recovered from the MSB sum bit.
      c_msb_in = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ res[DIGIT-1];
      res_w    = '0;
      res_w[DIGIT-1:0] = res;
      sum_next = (sum >> DIGIT) | (res_w << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // Subtraction is a + ~b + ~borrow_in.
                  a_q      <= a;
                  b_q      <= sub ? ~b : b;
                  sub_q    <= sub;
                  carry    <= sub ? ~cin : cin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               sum   <= sum_next;
               carry <= c_out;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  // A subtract carry-out of 1 means no borrow occurred.
                  cout      <= sub_q ? ~c_out : c_out;
                  ovf       <= c_msb_in ^ c_out;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               // in_ready returns only after this edge, so no beat can be
               // accepted in the same cycle as the result handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_carryadder.md
Name: serial_carryadder

Overview:
- Parametrised, digit-serial successor to the team's 4-bit combinational ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple-carry slice and a registered carry.
- Valid/ready handshake on input and output, with add/sub mode, carry/borrow out and signed overflow.
- Used where area matters more than throughput: one operation in flight, no overlap.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH; 1 <= DIGIT <= WIDTH. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (sub=0) or borrow-in (sub=1).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out (sub=0) or borrow-out (sub=1).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- FSM states: IDLE, RUN, DONE. Digit counter is clog2(N) bits wide, minimum 1 bit.
- Reset: state=IDLE, counter=0, carry=0, and in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a, (sub ? ~b : b) and sub. Set carry = sub ? ~cin : cin, counter=0, state to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds digit[counter] of a and of the latched b with the carry register. Writes the DIGIT result bits into sum[counter*DIGIT +: DIGIT], updates carry, increments counter.
  - On the edge processing digit N-1 (counter==N-1):
    - cout = sub ? ~carry_out : carry_out.
    - ovf = carry into MSB XOR carry out of MSB.
    - state to DONE, counter wraps to 0.
- Latency: out_valid rises exactly N clock edges after the accepting edge (16/4: 4 edges; DIGIT=WIDTH: 1 edge).
- DONE:
  - out_valid=1. sum, cout and ovf are held stable until out_valid&out_ready.
  - On out_valid&out_ready, go to IDLE and drop out_valid. sum, cout and ovf keep their values (don't-care while out_valid=0).
  - in_ready goes high the cycle after the output handshake. No same-cycle accept in DONE.
- in_valid and operand changes while in RUN or DONE are ignored. The latched operands are used.
- ovf equivalence:
  - sub=0: ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - sub=1: ovf = (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]).
- Reset mid-operation (RUN or DONE): the result is discarded and all outputs return to reset values on that edge. The next accepted operation is unaffected.
- No X propagation: all state registers are reset.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
- a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0. out_valid rises 4 edges after accept; in_ready=0 meanwhile.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- sub=1: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=1, ovf=0. a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=0, ovf=1. a=0x0010, b=0x0003, cin=1 -> sum=0x000C, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid and toggle in_valid with new operands -> sum, cout, ovf and out_valid held, in_ready=0. Assert out_ready -> out_valid drops next cycle and in_ready=1. The new beat is then accepted and correct.
- Reset asserted 2 cycles into RUN -> next cycle in_ready=1, out_valid=0, sum=0. Then 0x00FF+0x0001 -> 0x0100 after 4 edges.
- Parameter sweep DIGIT=1, 2, 16 with 1000 random operands and modes versus a reference model (a±b±cin) -> exact sum, cout and ovf match. Latency = 16, 8 and 1 edges respectively.
